// File: rtl/sccb_slave_responder.sv
// SCCB/I2C register-file target: oversampled SCL/SDA, START/STOP decode,
// sub-address pointer with auto-increment, one-cycle write strobes, read serving.
module sccb_slave_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h21,
  parameter int         FILTER_LEN = 3
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       oSDA_OE,
  output logic [7:0] oREG_ADDR,
  output logic [7:0] oREG_WDATA,
  output logic       oWR_STB,
  input  logic [7:0] iREG_RDATA,
  output logic       oBUSY
);

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, SUB, ACK_SUB, WDAT, ACK_WDAT, RDAT, MACK, IGNORE
  } state_t;

  assign I2C_SDAT = oSDA_OE ? 1'b0 : 1'bz;

  // Lane 0 = SCL, lane 1 = SDA; idle bus level is high.
  logic [1:0][1:0] syncQ;
  logic [1:0][3:0] fltCnt;
  logic [1:0]      filt, filtD;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      syncQ  <= '1;
      fltCnt <= '0;
      filt   <= 2'b11;
      filtD  <= 2'b11;
    end else begin
      syncQ[0] <= {syncQ[0][0], I2C_SCLK};
      syncQ[1] <= {syncQ[1][0], I2C_SDAT};
      filtD    <= filt;
      for (int i = 0; i < 2; i++) begin
        if (syncQ[i][1] == filt[i]) begin
          fltCnt[i] <= '0;
        end else if (fltCnt[i] == CNT_MAX) begin
          filt[i]   <= syncQ[i][1];
          fltCnt[i] <= '0;
        end else begin
          fltCnt[i] <= fltCnt[i] + 4'd1;
        end
      end
    end
  end

  logic sclRise, sclFall, startEv, stopEv, fSda;
  assign fSda    = filt[1];
  assign sclRise =  filt[0] & ~filtD[0];
  assign sclFall = ~filt[0] &  filtD[0];
  assign startEv =  filt[0] &  filtD[0] &  filtD[1] & ~filt[1];
  assign stopEv  =  filt[0] &  filtD[0] & ~filtD[1] &  filt[1];

  state_t     state, stateN;
  logic [3:0] bitCnt, bitCntN;
  logic [7:0] shReg, shRegN;
  logic       rw, rwN, mAck, mAckN;
  logic       oeN, stbN, busyN;
  logic [7:0] addrN, wdataN;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      bitCnt     <= '0;
      shReg      <= '0;
      rw         <= 1'b0;
      mAck       <= 1'b0;
      oSDA_OE    <= 1'b0;
      oREG_ADDR  <= '0;
      oREG_WDATA <= '0;
      oWR_STB    <= 1'b0;
      oBUSY      <= 1'b0;
    end else begin
      state      <= stateN;
      bitCnt     <= bitCntN;
      shReg      <= shRegN;
      rw         <= rwN;
      mAck       <= mAckN;
      oSDA_OE    <= oeN;
      oREG_ADDR  <= addrN;
      oREG_WDATA <= wdataN;
      oWR_STB    <= stbN;
      oBUSY      <= busyN;
    end
  end

  always_comb begin
    stateN  = state;
    bitCntN = bitCnt;
    shRegN  = shReg;
    rwN     = rw;
    mAckN   = mAck;
    oeN     = oSDA_OE;
    addrN   = oREG_ADDR;
    wdataN  = oREG_WDATA;
    stbN    = 1'b0;
    busyN   = oBUSY;
    if (stopEv) begin
      stateN  = IDLE;
      bitCntN = '0;
      oeN     = 1'b0;
      busyN   = 1'b0;
    end else if (startEv) begin
      // Repeated START keeps the register pointer; any partial byte is dropped.
      stateN  = DEV;
      bitCntN = '0;
      oeN     = 1'b0;
      busyN   = 1'b1;
    end else begin
      case (state)
        DEV, SUB, WDAT: begin
          if (sclRise && bitCnt < 4'd8) begin
            shRegN  = {shReg[6:0], fSda};
            bitCntN = bitCnt + 4'd1;
          end else if (sclFall && bitCnt == 4'd8) begin
            bitCntN = '0;
            if (state == DEV) begin
              if (shReg[7:1] == DEV_ADDR) begin
                stateN = ACK_DEV;
                rwN    = shReg[0];
                oeN    = 1'b1;
              end else begin
                stateN = IGNORE;
              end
            end else if (state == SUB) begin
              addrN  = shReg;
              oeN    = 1'b1;
              stateN = ACK_SUB;
            end else begin
              wdataN = shReg;
              stbN   = 1'b1;
              oeN    = 1'b1;
              stateN = ACK_WDAT;
            end
          end
        end
        ACK_DEV: if (sclFall) begin
          if (rw) begin
            shRegN  = iREG_RDATA;
            oeN     = ~iREG_RDATA[7];
            bitCntN = 4'd1;
            stateN  = RDAT;
          end else begin
            oeN    = 1'b0;
            stateN = SUB;
          end
        end
        ACK_SUB: if (sclFall) begin
          oeN    = 1'b0;
          stateN = WDAT;
        end
        ACK_WDAT: if (sclFall) begin
          oeN    = 1'b0;
          addrN  = oREG_ADDR + 8'd1;
          stateN = WDAT;
        end
        // bitCnt counts bits already placed on the bus.
        RDAT: if (sclFall) begin
          if (bitCnt == 4'd8) begin
            oeN    = 1'b0;
            mAckN  = 1'b0;
            stateN = MACK;
          end else begin
            shRegN  = {shReg[6:0], 1'b0};
            oeN     = ~shReg[6];
            bitCntN = bitCnt + 4'd1;
          end
        end
        MACK: begin
          if (sclRise) begin
            if (!fSda) begin
              addrN = oREG_ADDR + 8'd1;
              mAckN = 1'b1;
            end else begin
              stateN = IGNORE;
            end
          end else if (sclFall && mAck) begin
            // Pointer already advanced, so iREG_RDATA now reflects the next register.
            shRegN  = iREG_RDATA;
            oeN     = ~iREG_RDATA[7];
            bitCntN = 4'd1;
            mAckN   = 1'b0;
            stateN  = RDAT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_slave_responder.sv
// Directed bench: bit-banged SCCB master, pulled-up SDA, register file model.
module tb_sccb_slave_responder;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       scl = 1'b1;
  logic       mLow = 1'b0;
  wire        sda;
  logic       oSDA_OE, oWR_STB, oBUSY;
  logic [7:0] oREG_ADDR, oREG_WDATA, iREG_RDATA;
  logic [7:0] regFile [256];

  int nAssert = 0;
  int nFail = 0;
  int oeCnt = 0;
  int stbCnt = 0;
  logic [7:0] stbAddr [16];
  logic [7:0] stbData [16];

  pullup (sda);
  assign sda = mLow ? 1'b0 : 1'bz;
  assign iREG_RDATA = regFile[oREG_ADDR];

  always #5 iCLK = ~iCLK;

  sccb_slave_responder #(.DEV_ADDR(7'h21), .FILTER_LEN(3)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .I2C_SCLK(scl), .I2C_SDAT(sda),
    .oSDA_OE(oSDA_OE), .oREG_ADDR(oREG_ADDR), .oREG_WDATA(oREG_WDATA),
    .oWR_STB(oWR_STB), .iREG_RDATA(iREG_RDATA), .oBUSY(oBUSY)
  );

  always @(negedge iCLK) begin
    if (oSDA_OE) oeCnt <= oeCnt + 1;
    if (oWR_STB && stbCnt < 16) begin
      stbAddr[stbCnt] <= oREG_ADDR;
      stbData[stbCnt] <= oREG_WDATA;
      stbCnt <= stbCnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitN(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // Entered and left with SCL just pulled low.
  task automatic clkBit(input logic b, output logic busBit);
    waitN(10); mLow = ~b;
    waitN(15); scl = 1'b1;
    waitN(12); busBit = sda;
    waitN(13); scl = 1'b0;
  endtask

  task automatic startCond();
    if (!scl) begin
      waitN(10); mLow = 1'b0;
      waitN(15); scl = 1'b1;
      waitN(12);
    end else begin
      waitN(10);
    end
    mLow = 1'b1;
    waitN(25); scl = 1'b0;
  endtask

  task automatic stopCond();
    waitN(10); mLow = 1'b1;
    waitN(15); scl = 1'b1;
    waitN(15); mLow = 1'b0;
    waitN(25);
  endtask

  task automatic sendByte(input logic [7:0] d, output logic ack);
    logic bb;
    for (int i = 7; i >= 0; i--) clkBit(d[i], bb);
    clkBit(1'b1, bb);
    ack = ~bb;
  endtask

  task automatic readByte(input logic giveAck, output logic [7:0] d);
    logic bb;
    for (int i = 7; i >= 0; i--) begin
      clkBit(1'b1, bb);
      d[i] = bb;
    end
    clkBit(~giveAck, bb);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    logic [7:0] pat;
    int         oeMark;
    logic       bb;
    for (int i = 0; i < 256; i++) regFile[i] = 8'(i);
    regFile[8'h0A] = 8'h76;
    regFile[8'h05] = 8'hA5;
    regFile[8'h06] = 8'h3C;

    waitN(5);
    check("rst_oe", oSDA_OE, 1'b0);
    check("rst_addr", oREG_ADDR, 8'h00);
    check("rst_wdata", oREG_WDATA, 8'h00);
    check("rst_stb", oWR_STB, 1'b0);
    check("rst_busy", oBUSY, 1'b0);
    iRST_N = 1'b1;
    waitN(10);

    // Single register write
    startCond();
    waitN(2);
    check("t1_busy_start", oBUSY, 1'b1);
    sendByte(8'h42, ack); check("t1_ack_dev", ack, 1'b1);
    sendByte(8'h12, ack); check("t1_ack_sub", ack, 1'b1);
    sendByte(8'h80, ack); check("t1_ack_dat", ack, 1'b1);
    stopCond();
    check("t1_stb_cnt", stbCnt, 1);
    check("t1_stb_addr", stbAddr[0], 8'h12);
    check("t1_stb_data", stbData[0], 8'h80);
    check("t1_busy_stop", oBUSY, 1'b0);
    check("t1_addr_inc", oREG_ADDR, 8'h13);

    // Foreign device address
    oeMark = oeCnt;
    startCond();
    sendByte(8'h60, ack); check("t2_nack_dev", ack, 1'b0);
    sendByte(8'h12, ack); check("t2_nack_sub", ack, 1'b0);
    stopCond();
    check("t2_oe_never", oeCnt - oeMark, 0);
    check("t2_no_stb", stbCnt, 1);
    check("t2_addr_kept", oREG_ADDR, 8'h13);

    // Set pointer, then read with master NACK
    startCond();
    sendByte(8'h42, ack);
    sendByte(8'h0A, ack);
    stopCond();
    startCond();
    sendByte(8'h43, ack); check("t3_ack_rd", ack, 1'b1);
    readByte(1'b0, rd);
    check("t3_rdata", rd, 8'h76);
    check("t3_oe_released", oSDA_OE, 1'b0);
    stopCond();
    check("t3_addr_kept", oREG_ADDR, 8'h0A);

    // Burst write across pointer wrap
    startCond();
    sendByte(8'h42, ack);
    sendByte(8'hFF, ack);
    sendByte(8'h11, ack); check("t4_ack_d0", ack, 1'b1);
    sendByte(8'h22, ack); check("t4_ack_d1", ack, 1'b1);
    stopCond();
    check("t4_stb_cnt", stbCnt, 3);
    check("t4_stb0_addr", stbAddr[1], 8'hFF);
    check("t4_stb0_data", stbData[1], 8'h11);
    check("t4_stb1_addr", stbAddr[2], 8'h00);
    check("t4_stb1_data", stbData[2], 8'h22);
    check("t4_addr_end", oREG_ADDR, 8'h01);

    // Partial write aborted by repeated START, then sequential read
    startCond();
    sendByte(8'h42, ack);
    sendByte(8'h05, ack);
    pat = 8'hA0;
    for (int i = 7; i >= 4; i--) clkBit(pat[i], bb);
    startCond();
    sendByte(8'h43, ack); check("t5_ack_rd", ack, 1'b1);
    readByte(1'b1, rd); check("t5_rd0", rd, 8'hA5);
    readByte(1'b0, rd); check("t5_rd1", rd, 8'h3C);
    stopCond();
    check("t5_no_stb", stbCnt, 3);
    check("t5_addr_end", oREG_ADDR, 8'h06);

    // One-cycle SDA glitch while idle must not look like START
    waitN(10);
    mLow = 1'b1; waitN(1); mLow = 1'b0;
    waitN(20);
    check("t6_glitch_busy", oBUSY, 1'b0);

    // Reset during the sub-address ACK
    startCond();
    sendByte(8'h42, ack);
    pat = 8'h33;
    for (int i = 7; i >= 0; i--) clkBit(pat[i], bb);
    waitN(10);
    check("t7_oe_ack_sub", oSDA_OE, 1'b1);
    #1 iRST_N = 1'b0;
    #1;
    check("t7_oe_async", oSDA_OE, 1'b0);
    check("t7_sda_free", sda, 1'b1);
    waitN(3);
    iRST_N = 1'b1;
    oeMark = oeCnt;
    pat = 8'h42;
    for (int i = 7; i >= 0; i--) clkBit(pat[i], bb);
    clkBit(1'b1, bb);
    check("t7_idle_no_ack", bb, 1'b1);
    check("t7_idle_oe", oeCnt - oeMark, 0);
    check("t7_idle_busy", oBUSY, 1'b0);
    check("t7_addr_rst", oREG_ADDR, 8'h00);
    stopCond();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
